mux_stream_nx1: RTL and testbench
=================================

// Module: mux_stream_nx1
// PURPOSE
//  Parametrised N:1 data-path multiplexer with valid/ready handshake and output buffering.
//  Selects one of NUM_CH input channels by explicit select or by round-robin arbitration.
//  Pushes the selected word into an OUT_DEPTH-entry output FIFO, so downstream stalls never
//  feed back combinationally through the select path.
//  Sits between ALU/memory result producers and the register-file write-back path.
// PARAMETERS
//  DATA_W     64  width of every data word
//  NUM_CH     4   number of input channels (2..16)
//  OUT_DEPTH  2   output FIFO entries (power of 2, >=2)
// PORTS
//  CLK      in   1               clock, all state updates on posedge
//  RST      in   1               synchronous, active-high reset
//  I_DATA   in   NUM_CH*DATA_W   channel k occupies bits [k*DATA_W +: DATA_W]
//  I_VALID  in   NUM_CH          per-channel valid
//  I_READY  out  NUM_CH          per-channel ready
//  SEL      in   $clog2(NUM_CH)  explicit channel select (MODE=0)
//  MODE     in   1               0 = SEL-driven, 1 = round-robin (needs MUX_RR_ARB_EN)
//  Y        out  DATA_W          FIFO head word
//  Y_VALID  out  1               FIFO non-empty
//  Y_READY  in   1               downstream accepts Y
//  XFER_CNT out  32              accepted input transfers, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  - Reset (RST=1 at posedge): FIFO empty, Y=0, Y_VALID=0, XFER_CNT=0, rr pointer=NUM_CH-1.
//    RST wins over any simultaneous push/pop; in-flight FIFO contents are discarded.
//  - Grant (combinational):
//    MODE=0: grant=SEL. If SEL>=NUM_CH, there is no grant and all I_READY=0.
//    MODE=1: grant=first k with I_VALID[k], searched ptr+1, ptr+2, ... with wrap modulo NUM_CH.
//    No valid channel: no grant.
//  - I_READY[k] = (k==grant) && (count<OUT_DEPTH). count is the registered occupancy.
//    A pop in the same cycle does NOT free a slot for a push while count==OUT_DEPTH.
//  - Push = I_VALID[grant] && I_READY[grant]. Pop = Y_VALID && Y_READY. Both may occur in one
//    cycle; then count is unchanged and the FIFO order is preserved.
//  - Latency: a word accepted at edge t is visible on Y after edge t when the FIFO was empty.
//    Otherwise it is visible after all earlier words have popped.
//  - Y holds the head word while Y_VALID=1 && Y_READY=0. Y holds its last value when the FIFO
//    is empty.
//  - Pointers wrap modulo OUT_DEPTH. Occupancy counter width is $clog2(OUT_DEPTH+1).
//  - rr pointer <= grant on every push in MODE=1 only. It is unchanged in MODE=0.
//  - XFER_CNT increments by 1 per push and holds at all-ones.
//  - MODE or SEL may change on any cycle. The change affects the grant immediately and never
//    corrupts a word already buffered.
// CONFIGURATION
//  MUX_RR_ARB_EN defined: the round-robin picker and rr pointer are built, and MODE is honoured.
//  MUX_RR_ARB_EN undefined: MODE is ignored (treated as 0), there is no picker logic, and
//  the rr pointer is absent.
// STRUCTURE
//  - Shared project definition header holds the default DATA_W (64) and the NUM_CH / OUT_DEPTH
//    defaults as `define constants.
//  - One sub-module: mux_rr_picker (NUM_CH). Inputs: valid vector and pointer. Outputs: grant
//    index and a grant-found flag. It is purely combinational.
//  - FIFO storage, pointers and XFER_CNT live in the top module.
// TESTING
//  1 SEL mode: MODE=0, SEL=2, I_DATA ch2=1431655701, ch0=1431655700, all valid, Y_READY=1
//    -> Y=1431655701 one cycle later; I_READY=4'b0100.
//  2 Backpressure: Y_READY=0, ch1 streams 10,11,12 -> exactly 10,11 accepted and I_READY
//    drops to 0. Then Y_READY=1 -> Y yields 10,11,12 in order; XFER_CNT=3.
//  3 Round-robin: MODE=1, all 4 channels valid with data=k, Y_READY=1 -> Y sequence
//    0,1,2,3,0. With only ch3 and ch1 valid -> alternates 1,3,1,3.
//  4 Invalid select: MODE=0, SEL=3, NUM_CH=3 -> I_READY=0 and Y_VALID stays 0.
//  5 Reset mid-stream: FIFO holding 2 words, RST pulsed 1 cycle -> Y_VALID=0, Y=0 and
//    XFER_CNT=0 next cycle. In MODE=1 the next grant goes to ch0 first.
//  6 Build without MUX_RR_ARB_EN, MODE=1, SEL=1 -> behaves exactly as SEL mode (ch1 only).

Source files
------------

// File: rtl/mux_stream_nx1_pkg.sv
// Shared definitions for the mux_stream_nx1 block: project-wide default sizes
// (as `define constants) and the transfer-counter type.
// Optional feature macro used by this block: MUX_RR_ARB_EN (round-robin picker).
`ifndef MUX_STREAM_NX1_DEFS
`define MUX_STREAM_NX1_DEFS
`define MUX_DEF_DATA_W    64
`define MUX_DEF_NUM_CH    4
`define MUX_DEF_OUT_DEPTH 2
`endif

package mux_stream_nx1_pkg;

    localparam int XFER_W = 32;

    typedef logic [XFER_W-1:0] xfer_cnt_t;

    localparam xfer_cnt_t XFER_MAX = '1;

endpackage

// File: rtl/mux_rr_picker.sv
// Combinational round-robin picker: returns the first valid channel found when
// searching upward from ptr+1, wrapping modulo NUM_CH.
module mux_rr_picker
    import mux_stream_nx1_pkg::*;
#(
    parameter int NUM_CH = `MUX_DEF_NUM_CH,
    parameter int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] valid,
    input  logic [PW-1:0]     ptr,
    output logic [PW-1:0]     grant,
    output logic              found
);

    int idx;

    // Scan NUM_CH positions starting just after the last granted channel.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!found && valid[idx]) begin
                found = 1'b1;
                grant = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_stream_nx1.sv
// N:1 stream multiplexer with valid/ready handshake feeding an OUT_DEPTH-entry
// output FIFO. Channel choice is SEL-driven, or round-robin when MODE=1 and the
// design is built with MUX_RR_ARB_EN defined. Without MUX_RR_ARB_EN, MODE is
// ignored and no picker or rr pointer exists.
module mux_stream_nx1
    import mux_stream_nx1_pkg::*;
#(
    parameter int DATA_W    = `MUX_DEF_DATA_W,
    parameter int NUM_CH    = `MUX_DEF_NUM_CH,
    parameter int OUT_DEPTH = `MUX_DEF_OUT_DEPTH,
    parameter int PW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH*DATA_W-1:0] I_DATA,
    input  logic [NUM_CH-1:0]        I_VALID,
    output logic [NUM_CH-1:0]        I_READY,
    input  logic [PW-1:0]            SEL,
    input  logic                     MODE,
    output logic [DATA_W-1:0]        Y,
    output logic                     Y_VALID,
    input  logic                     Y_READY,
    output logic [31:0]              XFER_CNT
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    logic [PW-1:0]     grant;
    logic              grant_ok;
    logic [CW-1:0]     count;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [DATA_W-1:0] y_q;
    xfer_cnt_t         xfer_q;
    logic              not_full;
    logic              grant_valid;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    function automatic xfer_cnt_t sat_inc(input xfer_cnt_t v);
        return (v == XFER_MAX) ? v : v + xfer_cnt_t'(1);
    endfunction

`ifdef MUX_RR_ARB_EN
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] rr_grant;
    logic          rr_found;

    mux_rr_picker #(.NUM_CH(NUM_CH), .PW(PW)) u_picker (
        .valid (I_VALID),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .found (rr_found)
    );

    // Grant source: round-robin picker in MODE=1, explicit select otherwise.
    always_comb begin
        if (MODE) begin
            grant    = rr_grant;
            grant_ok = rr_found;
        end else begin
            grant    = SEL;
            grant_ok = (32'(SEL) < NUM_CH);
        end
    end

    // rr pointer remembers the last channel pushed in round-robin mode.
    always_ff @(posedge CLK) begin
        if (RST)
            rr_ptr <= PW'(NUM_CH - 1);
        else if (push && MODE)
            rr_ptr <= grant;
    end
`else
    logic unused_mode;
    assign unused_mode = MODE;

    // Grant source: explicit select only; out-of-range SEL grants nothing.
    always_comb begin
        grant    = SEL;
        grant_ok = (32'(SEL) < NUM_CH);
    end
`endif

    // Readiness uses registered occupancy only, so a same-cycle pop never
    // opens a slot and Y_READY has no combinational path to I_READY.
    assign not_full = (count < CW'(OUT_DEPTH));

    // Route the granted channel's data/valid and drive its ready.
    always_comb begin
        push_data   = '0;
        grant_valid = 1'b0;
        I_READY     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_ok && grant == PW'(k)) begin
                push_data   = I_DATA[k*DATA_W +: DATA_W];
                grant_valid = I_VALID[k];
                I_READY[k]  = not_full;
            end
        end
    end

    assign push     = grant_valid && not_full;
    assign pop      = (count != '0) && Y_READY;
    assign Y        = y_q;
    assign Y_VALID  = (count != '0);
    assign XFER_CNT = xfer_q;

    // FIFO control, head register and transfer counter; reset discards contents.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            y_q    <= '0;
            xfer_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && count == '0)
                y_q <= push_data;
            else if (pop) begin
                if (count > CW'(1))
                    y_q <= mem[rd_ptr + AW'(1)];
                else if (push)
                    y_q <= push_data;
            end
            if (push)
                xfer_q <= sat_inc(xfer_q);
        end
    end

    // FIFO storage write; data is not reset.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_mux_stream_nx1.sv
// Directed self-checking bench for mux_stream_nx1 (4-channel main instance and
// a 3-channel instance for the out-of-range select case). Round-robin steps are
// compiled only when MUX_RR_ARB_EN is defined; otherwise MODE=1 is checked to
// behave as SEL mode.
module tb_mux_stream_nx1;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] i_data;
    logic [3:0]   i_valid;
    logic [3:0]   i_ready;
    logic [1:0]   sel;
    logic         mode;
    logic [63:0]  y;
    logic         y_valid;
    logic         y_ready;
    logic [31:0]  xfer_cnt;

    logic [191:0] i_data3;
    logic [2:0]   i_valid3;
    logic [2:0]   i_ready3;
    logic [1:0]   sel3;
    logic         mode3;
    logic [63:0]  y3;
    logic         y_valid3;
    logic         y_ready3;
    logic [31:0]  xfer_cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_stream_nx1 #(.DATA_W(64), .NUM_CH(4), .OUT_DEPTH(2)) dut (
        .CLK(clk), .RST(rst), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(i_ready),
        .SEL(sel), .MODE(mode), .Y(y), .Y_VALID(y_valid), .Y_READY(y_ready),
        .XFER_CNT(xfer_cnt)
    );

    mux_stream_nx1 #(.DATA_W(64), .NUM_CH(3), .OUT_DEPTH(2)) dut3 (
        .CLK(clk), .RST(rst), .I_DATA(i_data3), .I_VALID(i_valid3), .I_READY(i_ready3),
        .SEL(sel3), .MODE(mode3), .Y(y3), .Y_VALID(y_valid3), .Y_READY(y_ready3),
        .XFER_CNT(xfer_cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ch(input int k, input logic [63:0] v);
        i_data[k*64 +: 64] = v;
    endtask

    initial begin
        rst = 1'b1; i_data = '0; i_valid = '0; sel = '0; mode = 1'b0; y_ready = 1'b0;
        i_data3 = '0; i_valid3 = '0; sel3 = '0; mode3 = 1'b0; y_ready3 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_y", y, 64'd0);
        chk("rst_yvalid", {63'd0, y_valid}, 64'd0);
        chk("rst_xfer", {32'd0, xfer_cnt}, 64'd0);
        chk("rst_iready_sel0", {60'd0, i_ready}, 64'd1);

        // 1: SEL mode
        set_ch(0, 64'd1431655700); set_ch(1, 64'd7); set_ch(2, 64'd1431655701); set_ch(3, 64'd9);
        sel = 2'd2; mode = 1'b0; i_valid = 4'b1111; y_ready = 1'b1;
        #1;
        chk("sel_iready", {60'd0, i_ready}, 64'b0100);
        tick();
        chk("sel_y", y, 64'd1431655701);
        chk("sel_yvalid", {63'd0, y_valid}, 64'd1);
        chk("sel_xfer", {32'd0, xfer_cnt}, 64'd1);
        i_valid = 4'b0000;
        tick();
        chk("sel_empty", {63'd0, y_valid}, 64'd0);
        chk("sel_y_hold", y, 64'd1431655701);

        // 2: Backpressure
        do_reset();
        y_ready = 1'b0; sel = 2'd1; i_valid = 4'b0010; set_ch(1, 64'd10);
        #1;
        chk("bp_iready0", {60'd0, i_ready}, 64'b0010);
        tick();
        chk("bp_y10", y, 64'd10);
        set_ch(1, 64'd11);
        tick();
        chk("bp_y_stall", y, 64'd10);
        set_ch(1, 64'd12);
        #1;
        chk("bp_iready_full", {60'd0, i_ready}, 64'd0);
        tick();
        chk("bp_xfer2", {32'd0, xfer_cnt}, 64'd2);
        chk("bp_y_hold", y, 64'd10);
        y_ready = 1'b1;
        #1;
        chk("bp_no_pop_free", {60'd0, i_ready}, 64'd0);
        tick();
        chk("bp_y11", y, 64'd11);
        tick();
        chk("bp_y12", y, 64'd12);
        chk("bp_xfer3", {32'd0, xfer_cnt}, 64'd3);
        i_valid = 4'b0000;
        tick();
        chk("bp_drained", {63'd0, y_valid}, 64'd0);

`ifdef MUX_RR_ARB_EN
        // 3: Round-robin
        do_reset();
        mode = 1'b1; y_ready = 1'b1; i_valid = 4'b1111;
        for (int k = 0; k < 4; k++) set_ch(k, 64'(k));
        tick(); chk("rr_0", y, 64'd0);
        tick(); chk("rr_1", y, 64'd1);
        tick(); chk("rr_2", y, 64'd2);
        tick(); chk("rr_3", y, 64'd3);
        tick(); chk("rr_0b", y, 64'd0);
        i_valid = 4'b1010;
        #1;
        chk("rr_iready_ch1", {60'd0, i_ready}, 64'b0010);
        tick(); chk("rr_alt1", y, 64'd1);
        tick(); chk("rr_alt3", y, 64'd3);
        tick(); chk("rr_alt1b", y, 64'd1);
        tick(); chk("rr_alt3b", y, 64'd3);
        i_valid = 4'b0000; mode = 1'b0;
        tick();
`else
        // 6: MODE ignored without the round-robin build
        do_reset();
        mode = 1'b1; sel = 2'd1; y_ready = 1'b1; i_valid = 4'b1111;
        for (int k = 0; k < 4; k++) set_ch(k, 64'(k + 100));
        #1;
        chk("norr_iready", {60'd0, i_ready}, 64'b0010);
        tick(); chk("norr_y_a", y, 64'd101);
        tick(); chk("norr_y_b", y, 64'd101);
        chk("norr_xfer", {32'd0, xfer_cnt}, 64'd2);
        i_valid = 4'b0000; mode = 1'b0;
        tick();
`endif

        // 4: Invalid select on 3-channel instance
        for (int k = 0; k < 3; k++) i_data3[k*64 +: 64] = 64'(k + 40);
        sel3 = 2'd3; i_valid3 = 3'b111; y_ready3 = 1'b1; mode3 = 1'b0;
        #1;
        chk("inv_iready", {61'd0, i_ready3}, 64'd0);
        tick();
        chk("inv_yvalid", {63'd0, y_valid3}, 64'd0);
        tick();
        chk("inv_xfer", {32'd0, xfer_cnt3}, 64'd0);
        sel3 = 2'd2;
        #1;
        chk("inv_sel2_iready", {61'd0, i_ready3}, 64'b100);
        tick();
        chk("inv_sel2_y", y3, 64'd42);
        i_valid3 = 3'b000;

        // 5: Reset mid-stream
        do_reset();
        mode = 1'b0; sel = 2'd0; y_ready = 1'b0; i_valid = 4'b0001; set_ch(0, 64'd55);
        tick();
        set_ch(0, 64'd66);
        tick();
        chk("mid_yvalid", {63'd0, y_valid}, 64'd1);
        chk("mid_xfer", {32'd0, xfer_cnt}, 64'd2);
        i_valid = 4'b0000;
        do_reset();
        chk("mid_rst_yvalid", {63'd0, y_valid}, 64'd0);
        chk("mid_rst_y", y, 64'd0);
        chk("mid_rst_xfer", {32'd0, xfer_cnt}, 64'd0);
        for (int k = 0; k < 4; k++) set_ch(k, 64'(k + 200));
        y_ready = 1'b1; i_valid = 4'b1111;
`ifdef MUX_RR_ARB_EN
        mode = 1'b1; sel = 2'd2;
`else
        mode = 1'b0; sel = 2'd0;
`endif
        #1;
        chk("mid_first_grant", {60'd0, i_ready}, 64'b0001);
        tick();
        chk("mid_first_y", y, 64'd200);
        i_valid = 4'b0000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
